// File: rtl/small_lpf_multi.sv
// small_lpf_multi: time-multiplexed multi-channel single-pole IIR low-pass filter (adds/shifts only).
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module small_lpf_multi #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int CH_W      = 2,
   parameter int MAX_SHIFT = 15,
   parameter int SHIFT_W   = 4,
   parameter bit SIGNED    = 1'b0
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               inValid,
   output logic               inReady,
   input  logic [CH_W-1:0]    inCh,
   input  logic [WIDTH-1:0]   dataIn,
   output logic               outValid,
   input  logic               outReady,
   output logic [CH_W-1:0]    outCh,
   output logic [WIDTH-1:0]   dataOut,
   input  logic               cfgWr,
   input  logic [CH_W-1:0]    cfgCh,
   input  logic [SHIFT_W-1:0] cfgShift
);

   localparam int ACC_W = WIDTH + MAX_SHIFT;

   logic [ACC_W-1:0]   r_acc [CHANNELS];
   logic [SHIFT_W-1:0] r_shift [CHANNELS];
   logic               r_outValid;
   logic [CH_W-1:0]    r_outCh;
   logic [WIDTH-1:0]   r_dataOut;

   logic               w_inChOk;
   logic               w_cfgChOk;
   logic               w_accept;
   logic               w_load;
   logic [ACC_W-1:0]   w_accSel;
   logic [SHIFT_W-1:0] w_kSel;
   logic [ACC_W-1:0]   w_ext;
   logic [ACC_W-1:0]   w_yPrev;
   logic [ACC_W-1:0]   w_accNew;
   logic [WIDTH-1:0]   w_dataNext;
   logic [SHIFT_W-1:0] w_cfgClamped;

   assign w_inChOk     = (32'(inCh) < 32'(CHANNELS));
   assign w_cfgChOk    = (32'(cfgCh) < 32'(CHANNELS));
   assign inReady      = !cfgWr && (!r_outValid || outReady);
   assign w_accept     = inValid && inReady;
   // Out-of-range channels are consumed by the handshake but never touch state.
   assign w_load       = w_accept && w_inChOk;
   assign w_cfgClamped = (32'(cfgShift) > 32'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : cfgShift;

   always_comb begin
      w_accSel = '0;
      w_kSel   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (inCh == CH_W'(i)) begin
            w_accSel = r_acc[i];
            w_kSel   = r_shift[i];
         end
      end
   end

   always_comb begin
      if (SIGNED) begin
         w_ext      = ACC_W'($signed(dataIn));
         w_yPrev    = ACC_W'($signed(w_accSel) >>> w_kSel);
         w_accNew   = w_accSel + w_ext - w_yPrev;
         w_dataNext = WIDTH'($signed(w_accNew) >>> w_kSel);
      end else begin
         w_ext      = ACC_W'(dataIn);
         w_yPrev    = w_accSel >> w_kSel;
         w_accNew   = w_accSel + w_ext - w_yPrev;
         w_dataNext = WIDTH'(w_accNew >> w_kSel);
      end
   end

   // A shift change also clears the accumulator so a smaller k cannot exceed the range bound.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i]   <= '0;
            r_shift[i] <= '0;
         end
         r_outValid <= 1'b0;
         r_outCh    <= '0;
         r_dataOut  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfgWr && w_cfgChOk && (cfgCh == CH_W'(i))) begin
               r_shift[i] <= w_cfgClamped;
               r_acc[i]   <= '0;
            end else if (w_load && (inCh == CH_W'(i))) begin
               r_acc[i] <= w_accNew;
            end
         end
         if (w_load) begin
            r_outValid <= 1'b1;
            r_outCh    <= inCh;
            r_dataOut  <= w_dataNext;
         end else if (outReady) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign outValid = r_outValid;
   assign outCh    = r_outCh;
   assign dataOut  = r_dataOut;

endmodule

`default_nettype wire

// File: tb/tb_small_lpf_multi.sv
// tb_small_lpf_multi: directed vector bench for small_lpf_multi (unsigned and signed instances).
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_small_lpf_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstN;

   logic       u_inValid, u_inReady, u_outValid, u_outReady, u_cfgWr;
   logic [1:0] u_inCh, u_outCh, u_cfgCh;
   logic [7:0] u_dataIn, u_dataOut;
   logic [4:0] u_cfgShift;

   logic       s_inValid, s_inReady, s_outValid, s_outReady, s_cfgWr;
   logic [0:0] s_inCh, s_outCh, s_cfgCh;
   logic [7:0] s_dataIn, s_dataOut;
   logic [3:0] s_cfgShift;

   small_lpf_multi #(.WIDTH(8), .CHANNELS(3), .CH_W(2), .MAX_SHIFT(15), .SHIFT_W(5), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rstN(rstN), .inValid(u_inValid), .inReady(u_inReady), .inCh(u_inCh),
      .dataIn(u_dataIn), .outValid(u_outValid), .outReady(u_outReady), .outCh(u_outCh),
      .dataOut(u_dataOut), .cfgWr(u_cfgWr), .cfgCh(u_cfgCh), .cfgShift(u_cfgShift));

   small_lpf_multi #(.WIDTH(8), .CHANNELS(2), .CH_W(1), .MAX_SHIFT(15), .SHIFT_W(4), .SIGNED(1'b1)) s_dut (
      .clk(clk), .rstN(rstN), .inValid(s_inValid), .inReady(s_inReady), .inCh(s_inCh),
      .dataIn(s_dataIn), .outValid(s_outValid), .outReady(s_outReady), .outCh(s_outCh),
      .dataOut(s_dataOut), .cfgWr(s_cfgWr), .cfgCh(s_cfgCh), .cfgShift(s_cfgShift));

   int tests = 0;
   int fails = 0;
   logic u_rdy;
   logic s_rdy;

   typedef struct {
      logic       v;
      logic [1:0] ch;
      logic [7:0] d;
      logic       cw;
      logic [1:0] cch;
      logic [4:0] ck;
      logic       ordy;
      logic       eRdy;
      logic       eV;
      logic [1:0] eCh;
      logic [7:0] eD;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input int v, input int ch, input int d, input int cw, input int cch,
                               input int ck, input int ordy, input int erdy, input int ev,
                               input int ech, input int ed);
      vec_t r;
      r.v = 1'(v); r.ch = 2'(ch); r.d = 8'(d); r.cw = 1'(cw); r.cch = 2'(cch); r.ck = 5'(ck);
      r.ordy = 1'(ordy); r.eRdy = 1'(erdy); r.eV = 1'(ev); r.eCh = 2'(ech); r.eD = 8'(ed);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at posedge+1: drive, sample inReady before the edge, then land at next posedge+1.
   task automatic u_step(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic cw,
                         input logic [1:0] cch, input logic [4:0] ck, input logic ordy);
      u_inValid = v; u_inCh = ch; u_dataIn = d; u_cfgWr = cw; u_cfgCh = cch; u_cfgShift = ck;
      u_outReady = ordy;
      #1 u_rdy = u_inReady;
      @(posedge clk); #1;
   endtask

   task automatic s_step(input logic v, input logic [0:0] ch, input logic [7:0] d, input logic cw,
                         input logic [0:0] cch, input logic [3:0] ck, input logic ordy);
      s_inValid = v; s_inCh = ch; s_dataIn = d; s_cfgWr = cw; s_cfgCh = cch; s_cfgShift = ck;
      s_outReady = ordy;
      #1 s_rdy = s_inReady;
      @(posedge clk); #1;
   endtask

   initial begin
      int acc_cnt;
      rstN = 1'b0;
      u_inValid = 0; u_inCh = 0; u_dataIn = 0; u_cfgWr = 0; u_cfgCh = 0; u_cfgShift = 0; u_outReady = 1;
      s_inValid = 0; s_inCh = 0; s_dataIn = 0; s_cfgWr = 0; s_cfgCh = 0; s_cfgShift = 0; s_outReady = 1;

      tbl[0]  = mk(0, 0,   0, 1, 0, 2, 1, 0, 0, 0,  0);
      tbl[1]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 25);
      tbl[2]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 43);
      tbl[3]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 58);
      tbl[4]  = mk(1, 0, 100, 1, 0, 2, 1, 0, 0, 0,  0);
      tbl[5]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 25);
      tbl[6]  = mk(1, 1,  37, 0, 0, 0, 1, 1, 1, 1, 37);
      tbl[7]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 43);
      tbl[8]  = mk(1, 1,  37, 0, 0, 0, 1, 1, 1, 1, 37);
      tbl[9]  = mk(1, 0, 100, 0, 0, 0, 1, 1, 1, 0, 58);
      tbl[10] = mk(1, 1,  37, 0, 0, 0, 1, 1, 1, 1, 37);
      tbl[11] = mk(1, 3, 200, 0, 0, 0, 1, 1, 0, 0,  0);
      tbl[12] = mk(1, 2,   9, 0, 0, 0, 1, 1, 1, 2,  9);
      tbl[13] = mk(0, 0,   0, 0, 0, 0, 1, 1, 0, 0,  0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset u outValid", int'(u_outValid), 0);
      chk("reset u dataOut", int'(u_dataOut), 0);
      chk("reset u inReady", int'(u_inReady), 1);
      chk("reset s outValid", int'(s_outValid), 0);
      rstN = 1'b1;
      @(posedge clk); #1;

      // Signed step with floor rounding and convergence.
      s_step(0, 0, 8'h00, 1, 0, 4'd2, 1);
      s_step(1, 0, 8'h9C, 0, 0, 4'd0, 1);
      chk("signed step1", int'($signed(s_dataOut)), -25);
      s_step(1, 0, 8'h9C, 0, 0, 4'd0, 1);
      chk("signed step2", int'($signed(s_dataOut)), -44);
      for (int n = 0; n < 60; n++) s_step(1, 0, 8'h9C, 0, 0, 4'd0, 1);
      chk("signed converge", int'($signed(s_dataOut)), -100);
      s_step(1, 1, 8'hFD, 0, 0, 4'd0, 1);
      chk("signed ch1 passthru", int'($signed(s_dataOut)), -3);
      chk("signed ch1 outCh", int'(s_outCh), 1);
      s_inValid = 0;

      for (int i = 0; i < 14; i++) begin
         u_step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].cw, tbl[i].cch, tbl[i].ck, tbl[i].ordy);
         chk($sformatf("tbl%0d inReady", i), int'(u_rdy), int'(tbl[i].eRdy));
         chk($sformatf("tbl%0d outValid", i), int'(u_outValid), int'(tbl[i].eV));
         if (tbl[i].eV) begin
            chk($sformatf("tbl%0d outCh", i), int'(u_outCh), int'(tbl[i].eCh));
            chk($sformatf("tbl%0d dataOut", i), int'(u_dataOut), int'(tbl[i].eD));
         end
      end

      // Backpressure: ch0 acc=232, k=2.
      acc_cnt = 0;
      for (int n = 0; n < 5; n++) begin
         u_step(1, 0, 100, 0, 0, 0, 0);
         if (u_rdy) acc_cnt++;
         chk($sformatf("bp%0d outValid", n), int'(u_outValid), 1);
         chk($sformatf("bp%0d dataOut", n), int'(u_dataOut), 68);
         chk($sformatf("bp%0d outCh", n), int'(u_outCh), 0);
      end
      chk("bp accept count", acc_cnt, 1);
      u_step(1, 0, 100, 0, 0, 0, 1);
      chk("bp release inReady", int'(u_rdy), 1);
      chk("bp release data1", int'(u_dataOut), 76);
      u_step(1, 0, 100, 0, 0, 0, 1);
      chk("bp release data2", int'(u_dataOut), 82);
      u_step(0, 0, 0, 0, 0, 0, 1);
      chk("bp drain outValid", int'(u_outValid), 0);

      // Config rewrite with a pending output held.
      u_step(0, 0, 0, 1, 0, 4, 1);
      u_step(1, 0, 200, 0, 0, 0, 1);
      chk("cfg k4 s1", int'(u_dataOut), 12);
      u_step(1, 0, 200, 0, 0, 0, 1);
      chk("cfg k4 s2", int'(u_dataOut), 24);
      u_step(1, 0, 200, 0, 0, 0, 1);
      chk("cfg k4 s3", int'(u_dataOut), 35);
      u_step(1, 0, 200, 1, 0, 1, 0);
      chk("cfg inReady", int'(u_rdy), 0);
      chk("cfg pending valid", int'(u_outValid), 1);
      chk("cfg pending data", int'(u_dataOut), 35);
      u_step(1, 0, 200, 0, 0, 0, 1);
      chk("cfg k1 data", int'(u_dataOut), 100);

      // Shift clamp: 31 stored as 15.
      u_step(0, 0, 0, 1, 2, 31, 1);
      for (int n = 1; n <= 129; n++) begin
         u_step(1, 2, 255, 0, 0, 0, 1);
         if (n == 128) chk("clamp n128", int'(u_dataOut), 0);
         if (n == 129) chk("clamp n129", int'(u_dataOut), 1);
      end
      u_inValid = 0;

      // Asynchronous reset between edges while output pending.
      #2 rstN = 1'b0;
      #1;
      chk("async rst outValid", int'(u_outValid), 0);
      chk("async rst dataOut", int'(u_dataOut), 0);
      chk("async rst outCh", int'(u_outCh), 0);
      rstN = 1'b1;
      @(posedge clk); #1;
      u_step(1, 0, 77, 0, 0, 0, 1);
      chk("post rst ch0", int'(u_dataOut), 77);
      u_step(1, 2, 5, 0, 0, 0, 1);
      chk("post rst ch2", int'(u_dataOut), 5);
      chk("post rst ch2 outCh", int'(u_outCh), 2);
      u_step(0, 0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
